uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
Buffered front end for the UART driver's transmit handshake (tx_start / tx_data / tx_ready).
- Accepts words from upstream MITM logic into a FIFO at up to one word per clock.
- Drains the FIFO one frame at a time, initiating each transfer only when the driver reports ready.
- Sits between the interception/modification logic and the UART driver, so bursty producers never stall on the serial line.

Parameters:
NUM_DATA_BITS, 8, width of one data word; must match the driver.
FIFO_DEPTH, 16, number of buffered words; power of two, minimum 2.
GAP_CYCLES, 0, idle clock cycles inserted between frames; used only with the optional feature.

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
wr_en  input  1  push wr_data into FIFO this cycle.
wr_data  input  NUM_DATA_BITS  word to buffer.
full  output  1  FIFO holds FIFO_DEPTH words.
empty  output  1  FIFO holds 0 words.
fill_level  output  $clog2(FIFO_DEPTH)+1  current word count.
overflow  output  1  sticky; a write was dropped.
ovf_clear  input  1  clears overflow.
busy  output  1  FSM not in IDLE.
tx_ready  input  1  from driver; high = driver idle.
tx_start  output  1  to driver; one-cycle start pulse.
tx_data  output  NUM_DATA_BITS  to driver; word being sent.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx_start=0, tx_data=0, fill_level=0, empty=1, full=0, overflow=0, busy=0.
  - FSM goes to IDLE; pointers go to 0; FIFO contents are discarded.
  - Reset mid-frame drops tx_start immediately. The driver's in-progress frame is not this block's concern.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - fill_level is registered and updates on the edge after a push/pop.
  - Push while full is dropped and sets overflow on the same edge, even if a pop happens that cycle.
  - Push and pop in the same cycle, not full: fill_level unchanged.
  - ovf_clear has priority over a same-cycle overflow set: overflow ends at 0.
- FSM:
  - IDLE: if !empty && tx_ready, pop the head word into tx_data and go to START. Otherwise stay.
  - START: tx_start=1 for exactly this cycle; tx_data stable. Next state is WAIT_BUSY.
  - WAIT_BUSY: stay until tx_ready==0, then go to WAIT_READY. Protects against a stale ready level.
  - WAIT_READY: stay until tx_ready==1, then go to IDLE, or to GAP if the feature is enabled and GAP_CYCLES>0.
- Timing and data rules:
  - Latency: wr_en high in cycle n into an empty FIFO with tx_ready=1 gives tx_start high in cycle n+2.
  - tx_data changes only on the IDLE→START edge and holds until the next pop.
  - Words leave in write order; no word is duplicated or skipped.
  - busy=1 in every state except IDLE.

Optional Feature:
Macro: UART_TX_BUF_GAP_EN
- Defined:
  - GAP state is present, with a counter of width $clog2(GAP_CYCLES+1).
  - After WAIT_READY, the FSM spends exactly GAP_CYCLES cycles in GAP with busy=1, then returns to IDLE.
  - GAP_CYCLES=0 skips GAP entirely.
- Not defined:
  - No GAP state or counter; GAP_CYCLES is ignored.
  - WAIT_READY returns straight to IDLE.

Test Plan:
Bench setup for all scenarios:
- NUM_DATA_BITS=12, FIFO_DEPTH=4.
- Driver model: drops tx_ready 1 cycle after tx_start and holds it low 1456 cycles (14 bits × 104).

Scenarios:
1. Single word: reset, push 12'h0b5 in cycle n with tx_ready=1 -> tx_start pulses in cycle n+2 only, tx_data=12'h0b5, fill_level returns to 0, busy=0 after tx_ready rises.
2. Burst and order: push 12'h4e6, 12'he91, 12'h51d on consecutive cycles -> three tx_start pulses, each after tx_ready re-rises; tx_data sequence 4e6, e91, 51d.
3. Full/overflow: hold tx_ready=0, push 5 words (1..5) -> full=1 after 4th; 5th dropped; overflow=1. Pulse ovf_clear -> overflow=0. Release tx_ready -> words 1..4 sent.
4. Simultaneous push/pop: fill_level=4 while a pop occurs and wr_en=1 in the same cycle -> write dropped, overflow=1, fill_level=3. Separately, fill_level=2 with push+pop in one cycle -> fill_level stays 2.
5. Reset mid-operation: rst_n low during WAIT_READY with 2 words queued -> all outputs at reset values immediately. After release with tx_ready=1, no tx_start.
6. With UART_TX_BUF_GAP_EN, GAP_CYCLES=10: two queued words -> second tx_start occurs 10 cycles later than without the macro.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: FIFO-backed front end for the UART driver's transmit handshake.
// Upstream logic pushes words at up to one per clock. A small FSM drains the FIFO
// one frame at a time: it raises tx_start only when the driver reports tx_ready.
// Optional feature macro: UART_TX_BUF_GAP_EN. When it is defined, GAP_CYCLES idle
// cycles are inserted after each frame.
module uart_tx_buffer #(
    parameter int NUM_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [NUM_DATA_BITS-1:0]      wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    input  logic                          ovf_clear,
    output logic                          busy,
    input  logic                          tx_ready,
    output logic                          tx_start,
    output logic [NUM_DATA_BITS-1:0]      tx_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef UART_TX_BUF_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_READY,
        S_GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_READY
    } state_t;
`endif

    // Storage and state
    logic [NUM_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic [NUM_DATA_BITS-1:0] tx_data_q, tx_data_d;
    state_t                   state_q, state_d;
`ifdef UART_TX_BUF_GAP_EN
    logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
`endif

    logic push;
    logic pop;

    // Status decode from the registered count
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign fill_level = count_q;
    assign overflow   = overflow_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = (state_q == S_START);
    assign busy       = (state_q != S_IDLE);

    // A write is dropped when the FIFO is full, even if a pop frees a slot this cycle
    assign push = wr_en && !full;

    // FIFO storage write port
    // NOTE: the data array has no reset; reset only clears pointers and count, which
    // makes the old contents unreachable and lets the array map to plain RAM.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointer, count and sticky overflow next-state
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear wins over a same-cycle overflow set
        if (ovf_clear) begin
            overflow_d = 1'b0;
        end else if (wr_en && full) begin
            overflow_d = 1'b1;
        end
    end

    // Transmit FSM next-state, pop request and output word
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        tx_data_d = tx_data_q;
`ifdef UART_TX_BUF_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!empty && tx_ready) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = S_START;
                end
            end

            S_START: begin
                state_d = S_WAIT_BUSY;
            end

            // Wait for the driver to acknowledge, so a stale ready level is not
            // mistaken for the end of the frame
            S_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = S_WAIT_READY;
                end
            end

            S_WAIT_READY: begin
                if (tx_ready) begin
`ifdef UART_TX_BUF_GAP_EN
                    if (GAP_CYCLES > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end

`ifdef UART_TX_BUF_GAP_EN
            // Counter is loaded with GAP_CYCLES-1, so GAP lasts exactly GAP_CYCLES cycles
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
            state_q    <= S_IDLE;
`ifdef UART_TX_BUF_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            state_q    <= state_d;
`ifdef UART_TX_BUF_GAP_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed self-checking bench for uart_tx_buffer.
// NUM_DATA_BITS=12, FIFO_DEPTH=4. A driver model drops tx_ready one cycle after
// tx_start and holds it low for 1456 cycles. With UART_TX_BUF_GAP_EN defined,
// GAP_CYCLES=10 stretches each frame by 10 cycles.
module tb_uart_tx_buffer;

    localparam int NDB    = 12;
    localparam int DEPTH  = 4;
    localparam int GAPC   = 10;
    localparam int LOW    = 1456;
    localparam int BUDGET = 3000;
    // Start-to-start spacing of back-to-back frames. tx_ready is low for LOW cycles
    // starting one cycle after tx_start. WAIT_READY sees ready one cycle later,
    // then IDLE pops, then START follows.
`ifdef UART_TX_BUF_GAP_EN
    localparam int FRAME = LOW + 3 + GAPC;
`else
    localparam int FRAME = LOW + 3;
`endif

    logic           sys_clk = 1'b0;
    logic           rst_n;
    logic           wr_en;
    logic [NDB-1:0] wr_data;
    logic           full, empty, overflow, ovf_clear, busy, tx_ready, tx_start;
    logic [2:0]     fill_level;
    logic [NDB-1:0] tx_data;

    logic hold_low;
    logic drv_kill;
    logic drv_ready;
    logic drv_pend;
    int   drv_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    assign tx_ready = drv_ready & ~hold_low;

    uart_tx_buffer #(
        .NUM_DATA_BITS(NDB),
        .FIFO_DEPTH   (DEPTH),
        .GAP_CYCLES   (GAPC)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .fill_level(fill_level),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .busy      (busy),
        .tx_ready  (tx_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data)
    );

    // Driver model. It acts 1 time unit after each rising edge, so it never races
    // the stimulus, which is applied on falling edges.
    initial begin
        drv_ready = 1'b1;
        drv_pend  = 1'b0;
        drv_cnt   = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (drv_kill) begin
                drv_pend  = 1'b0;
                drv_cnt   = 0;
                drv_ready = 1'b1;
            end else begin
                if (drv_pend) begin
                    drv_pend  = 1'b0;
                    drv_ready = 1'b0;
                    drv_cnt   = LOW;
                end else if (drv_cnt > 0) begin
                    drv_cnt = drv_cnt - 1;
                    if (drv_cnt == 0) drv_ready = 1'b1;
                end
                if (tx_start) drv_pend = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Advance until busy drops, bounded; returns the elapsed cycle count
    task automatic wait_idle(input string tag, output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < BUDGET) begin
            tick(1);
            cyc++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Advance to the next tx_start (at least one cycle), then check the word and spacing
    task automatic expect_frame(input string tag, input logic [NDB-1:0] exp_data, input int exp_cyc);
        int cyc;
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (tx_start !== 1'b1 && cyc < BUDGET);
        check({tag, "_start"}, 32'(tx_start), 32'd1);
        check({tag, "_data"},  32'(tx_data),  32'(exp_data));
        check({tag, "_gap"},   32'(cyc),      32'(exp_cyc));
    endtask

    initial begin
        int cyc;
        logic seen;

        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        ovf_clear = 1'b0;
        hold_low  = 1'b0;
        drv_kill  = 1'b0;
        tick(2);

        // Reset values
        check("rst_tx_start", 32'(tx_start),   32'd0);
        check("rst_tx_data",  32'(tx_data),    32'd0);
        check("rst_fill",     32'(fill_level), 32'd0);
        check("rst_empty",    32'(empty),      32'd1);
        check("rst_full",     32'(full),       32'd0);
        check("rst_ovf",      32'(overflow),   32'd0);
        check("rst_busy",     32'(busy),       32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1. Single word: push in cycle n, tx_start in cycle n+2
        wr_en = 1'b1; wr_data = 12'h0b5;
        tick(1);
        wr_en = 1'b0;
        check("s1_n1_start", 32'(tx_start),   32'd0);
        check("s1_n1_fill",  32'(fill_level), 32'd1);
        check("s1_n1_busy",  32'(busy),       32'd0);
        tick(1);
        check("s1_n2_start", 32'(tx_start),   32'd1);
        check("s1_n2_data",  32'(tx_data),    32'h0b5);
        check("s1_n2_fill",  32'(fill_level), 32'd0);
        check("s1_n2_busy",  32'(busy),       32'd1);
        tick(1);
        check("s1_n3_start", 32'(tx_start),   32'd0);
        wait_idle("s1", cyc);
        check("s1_busy_len", 32'(cyc),        32'(FRAME - 2));
        check("s1_data_hold",32'(tx_data),    32'h0b5);
        check("s1_empty",    32'(empty),      32'd1);

        // 2. Burst of three on consecutive cycles; order and spacing
        wr_en = 1'b1; wr_data = 12'h4e6;
        tick(1);
        wr_data = 12'he91;
        tick(1);
        wr_data = 12'h51d;
        check("s2_w1_start", 32'(tx_start),   32'd1);
        check("s2_w1_data",  32'(tx_data),    32'h4e6);
        tick(1);
        wr_en = 1'b0;
        check("s2_fill",     32'(fill_level), 32'd2);
        expect_frame("s2_w2", 12'he91, FRAME - 1);
        expect_frame("s2_w3", 12'h51d, FRAME);
        wait_idle("s2", cyc);
        check("s2_empty",    32'(empty),      32'd1);

        // 3. Fill, overflow, clear, clear priority, then drain 1..4
        hold_low = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                check("s3_full4",   32'(full),       32'd1);
                check("s3_fill4",   32'(fill_level), 32'd4);
                check("s3_ovf_pre", 32'(overflow),   32'd0);
            end
            wr_en = 1'b1; wr_data = NDB'(i);
            tick(1);
        end
        wr_en = 1'b0;
        check("s3_ovf_set",  32'(overflow),   32'd1);
        check("s3_fill_kept",32'(fill_level), 32'd4);
        ovf_clear = 1'b1;
        tick(1);
        ovf_clear = 1'b0;
        check("s3_ovf_clr",  32'(overflow),   32'd0);
        wr_en = 1'b1; wr_data = 12'h0ff; ovf_clear = 1'b1;
        tick(1);
        wr_en = 1'b0; ovf_clear = 1'b0;
        check("s3_clr_prio", 32'(overflow),   32'd0);
        check("s3_fill_prio",32'(fill_level), 32'd4);
        hold_low = 1'b0;
        expect_frame("s3_w1", 12'h001, 1);
        expect_frame("s3_w2", 12'h002, FRAME);
        expect_frame("s3_w3", 12'h003, FRAME);
        expect_frame("s3_w4", 12'h004, FRAME);
        wait_idle("s3", cyc);
        check("s3_empty",    32'(empty),      32'd1);

        // 4a. Push while full in the same cycle as a pop: dropped, overflow set
        hold_low = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_data = NDB'(12'h0a0 + i);
            tick(1);
        end
        check("s4_fill4",    32'(fill_level), 32'd4);
        hold_low = 1'b0;
        wr_en = 1'b1; wr_data = 12'habc;
        tick(1);
        wr_en = 1'b0;
        check("s4_fill3",    32'(fill_level), 32'd3);
        check("s4_ovf",      32'(overflow),   32'd1);
        check("s4_w1_start", 32'(tx_start),   32'd1);
        check("s4_w1_data",  32'(tx_data),    32'h0a1);
        expect_frame("s4_w2", 12'h0a2, FRAME);
        check("s4_fill2",    32'(fill_level), 32'd2);

        // 4b. Push and pop in the same cycle at fill_level 2: level unchanged
        wait_idle("s4", cyc);
        check("s4_fill2_idle", 32'(fill_level), 32'd2);
        wr_en = 1'b1; wr_data = 12'h777;
        tick(1);
        wr_en = 1'b0;
        check("s4_pp_fill",  32'(fill_level), 32'd2);
        check("s4_w3_start", 32'(tx_start),   32'd1);
        check("s4_w3_data",  32'(tx_data),    32'h0a3);

        // 5. Reset during WAIT_READY with two words queued
        tick(5);
        check("s5_pre_busy", 32'(busy),       32'd1);
        check("s5_pre_fill", 32'(fill_level), 32'd2);
        check("s5_pre_ovf",  32'(overflow),   32'd1);
        rst_n = 1'b0;
        #1;
        check("s5_tx_start", 32'(tx_start),   32'd0);
        check("s5_tx_data",  32'(tx_data),    32'd0);
        check("s5_fill",     32'(fill_level), 32'd0);
        check("s5_empty",    32'(empty),      32'd1);
        check("s5_full",     32'(full),       32'd0);
        check("s5_ovf",      32'(overflow),   32'd0);
        check("s5_busy",     32'(busy),       32'd0);
        drv_kill = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        drv_kill = 1'b0;
        check("s5_ready",    32'(tx_ready),   32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (tx_start === 1'b1) seen = 1'b1;
        end
        check("s5_no_start", 32'(seen),       32'd0);
        check("s5_post_busy",32'(busy),       32'd0);
        check("s5_post_fill",32'(fill_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
